// File: rtl/barrel_shifter_optimized.sv
// barrel_shifter_optimized: 32-bit RV32 shifter (SLL/SRL/SRA), one log right-shift
// network with bit-reversal for left shifts; combinational res plus registered res_q.
//
// Ports:
//   clk              - clock, rising edge
//   rst_n            - synchronous active-low reset (registered path only)
//   opranda          - value to be shifted
//   oprandb          - shift amount 0..XLEN-1
//   right_flag       - 1 = right shift, 0 = left shift
//   right_arith_flag - 1 = sign-fill right shift (ignored for left shifts)
//   in_valid         - qualifies inputs for the registered path
//   res              - combinational shift result
//   res_q            - registered result, 1-cycle latency, holds when in_valid=0
//   out_valid        - registered in_valid
module barrel_shifter_optimized #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    opranda,
    input  logic [SHAMT_W-1:0] oprandb,
    input  logic               right_flag,
    input  logic               right_arith_flag,
    input  logic               in_valid,
    output logic [XLEN-1:0]    res,
    output logic [XLEN-1:0]    res_q,
    output logic               out_valid
);

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

    // stage[0] is the (possibly reversed) operand, stage[SHAMT_W] the shifted value
    logic [XLEN-1:0] stage [0:SHAMT_W];
    logic            fill;

    // Sign fill only matters for arithmetic right shifts; left shifts
    // (reversed right shifts) and logical shifts always fill with zero.
    assign fill     = right_flag & right_arith_flag & opranda[XLEN-1];
    assign stage[0] = right_flag ? opranda : bitrev(opranda);

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [XLEN-1:0] shifted;
        assign shifted      = {{S{fill}}, stage[k][XLEN-1:S]};
        assign stage[k+1]   = oprandb[k] ? shifted : stage[k];
    end

    assign res = right_flag ? stage[SHAMT_W] : bitrev(stage[SHAMT_W]);

    // Registered copy for pipelined/retimed consumers.
    logic [XLEN-1:0] res_d;
    logic            valid_d;

    always_comb begin
        res_d   = in_valid ? res : res_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            res_q     <= res_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_barrel_shifter_optimized.sv
// tb_barrel_shifter_optimized: directed + random self-checking bench for the
// shifter; registered results tracked through an expected-value queue.
module tb_barrel_shifter_optimized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] opranda;
    logic [4:0]  oprandb;
    logic        right_flag;
    logic        right_arith_flag;
    logic        in_valid;
    logic [31:0] res;
    logic [31:0] res_q;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_q [$];
    logic [31:0] held = '0;

    always #5 clk = ~clk;

    barrel_shifter_optimized dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opranda          (opranda),
        .oprandb          (oprandb),
        .right_flag       (right_flag),
        .right_arith_flag (right_arith_flag),
        .in_valid         (in_valid),
        .res              (res),
        .res_q            (res_q),
        .out_valid        (out_valid)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                          input logic r, input logic ar);
        logic [31:0] y;
        if (!r)      y = a << b;
        else if (ar) y = $signed(a) >>> b;
        else         y = a >> b;
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] b,
                         input logic r, input logic ar, input logic v,
                         input string tag, input logic [31:0] exp_res);
        logic [31:0] m;
        opranda          = a;
        oprandb          = b;
        right_flag       = r;
        right_arith_flag = ar;
        in_valid         = v;
        #1;
        m = model(a, b, r, ar);
        check(tag, res, exp_res);
        if (v && rst_n) sb_q.push_back(m);
    endtask

    // Advance one edge and check the registered outputs against the scoreboard.
    task automatic tick();
        logic exp_ov;
        logic rst_at_edge;
        logic v_at_edge;
        rst_at_edge = rst_n;
        v_at_edge   = in_valid;
        @(posedge clk);
        #1;
        exp_ov = rst_at_edge & v_at_edge;
        if (!rst_at_edge) begin
            sb_q.delete();
            held = '0;
        end else if (v_at_edge) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=%h expected=none", res_q);
            end else begin
                held = sb_q.pop_front();
            end
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        check("res_q", res_q, held);
    endtask

    initial begin
        rst_n            = 1'b0;
        opranda          = '0;
        oprandb          = '0;
        right_flag       = 1'b0;
        right_arith_flag = 1'b0;
        in_valid         = 1'b0;

        tick();
        tick();

        rst_n = 1'b1;
        drive(32'hA5A5A5A5, 5'd1, 1'b1, 1'b0, 1'b1, "srl1_reg", 32'h52D2D2D2);
        tick();
        check("res_q_52d", res_q, 32'h52D2D2D2);
        drive(32'h12345678, 5'd3, 1'b0, 1'b0, 1'b0, "sll3_noval", 32'h91A2B3C0);
        tick();
        check("res_q_hold", res_q, 32'h52D2D2D2);
        rst_n = 1'b0;
        drive(32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 1'b1, "drop_tx", 32'hFFFFFFFF);
        tick();
        check("res_q_rst", res_q, 32'h0);
        rst_n = 1'b1;

        drive(32'hA5A5A5A5, 5'd16, 1'b1, 1'b0, 1'b1, "srl16", 32'h0000A5A5);
        tick();
        drive(32'hA5A5A5A5, 5'd1,  1'b0, 1'b0, 1'b1, "sll1", 32'h4B4B4B4A);
        tick();
        drive(32'hA5A5A5A5, 5'd16, 1'b0, 1'b0, 1'b1, "sll16", 32'hA5A50000);
        tick();
        drive(32'h00000001, 5'd31, 1'b0, 1'b0, 1'b1, "sll31", 32'h80000000);
        tick();
        drive(32'hA5A5A5A5, 5'd1,  1'b0, 1'b1, 1'b1, "sll1_arith", 32'h4B4B4B4A);
        tick();
        drive(32'hA5A5A5A5, 5'd0,  1'b0, 1'b0, 1'b1, "zero_sll", 32'hA5A5A5A5);
        tick();
        drive(32'hA5A5A5A5, 5'd0,  1'b1, 1'b0, 1'b1, "zero_srl", 32'hA5A5A5A5);
        tick();
        drive(32'hA5A5A5A5, 5'd0,  1'b1, 1'b1, 1'b1, "zero_sra", 32'hA5A5A5A5);
        tick();
        drive(32'hA5A5A5A5, 5'd1,  1'b1, 1'b1, 1'b1, "sra1", 32'hD2D2D2D2);
        tick();
        drive(32'hA5A5A5A5, 5'd16, 1'b1, 1'b1, 1'b1, "sra16", 32'hFFFFA5A5);
        tick();
        drive(32'h80000001, 5'd31, 1'b1, 1'b1, 1'b1, "sra31_neg", 32'hFFFFFFFF);
        tick();
        drive(32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 1'b1, "sra31_pos", 32'h00000000);
        tick();
        drive(32'h80000000, 5'd31, 1'b1, 1'b0, 1'b1, "srl31", 32'h00000001);
        tick();

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [4:0]  b;
            logic        r;
            logic        ar;
            logic        v;
            a  = $urandom;
            b  = 5'($urandom_range(0, 31));
            r  = 1'($urandom_range(0, 1));
            ar = 1'($urandom_range(0, 1));
            v  = 1'($urandom_range(0, 1));
            drive(a, b, r, ar, v, "rand_res", model(a, b, r, ar));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_optimized.md
Name: barrel_shifter_optimized

Overview:
- Single-datapath 32-bit barrel shifter for the RV32 ALU; implements SLL/SRL/SRA (and immediate forms) from one logarithmic right-shift network.
- Left shifts are done by bit-reversing the operand in, right-shifting, and bit-reversing the result out.
- Provides a combinational result consumed by the ALU result mux in the same cycle, plus a registered copy with valid for pipelined or retimed use.

Parameters:
- XLEN, 32, data width in bits; the design must support XLEN=32.
- SHAMT_W, 5, shift-amount width, equal to $clog2(XLEN); derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- opranda  input  XLEN  value to be shifted.
- oprandb  input  SHAMT_W  shift amount, unsigned 0..31; upper rs2 bits are masked by the caller.
- right_flag  input  1  1 = right shift, 0 = left shift.
- right_arith_flag  input  1  1 = arithmetic (sign-fill) right shift; ignored when right_flag=0.
- in_valid  input  1  qualifies inputs for the registered path.
- res  output  XLEN  combinational shift result.
- res_q  output  XLEN  registered result, 1-cycle latency.
- out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path (res):
  - res is a pure function of the current opranda, oprandb, right_flag and right_arith_flag, independent of clk, rst_n and in_valid.
  - Zero-cycle latency; res is valid within the same delta after the inputs settle.
- Operations:
  - Left (right_flag=0): res = opranda << oprandb, zero fill from the LSB. right_arith_flag has no effect.
  - Logical right (right_flag=1, right_arith_flag=0): res = opranda >> oprandb, zero fill from the MSB.
  - Arithmetic right (right_flag=1, right_arith_flag=1): res = $signed(opranda) >>> oprandb, filling with opranda[31].
- Datapath structure:
  - Input mux: t0 = right_flag ? opranda : bitreverse(opranda).
  - Fill bit: f = right_flag & right_arith_flag & opranda[31].
  - Five stages k=0..4: if oprandb[k] is set, shift right by 2^k and insert f into the vacated MSBs; otherwise pass through.
  - Output mux: res = right_flag ? t5 : bitreverse(t5).
  - No `<<`/`>>` operators on variable amounts are used; only the stage muxes.
- Boundary conditions:
  - oprandb=0 returns opranda unchanged in all modes.
  - oprandb=31 leaves a single surviving bit (left: bit 0 moved to 31; logical right: bit 31 moved to 0; arithmetic: all bits equal to opranda[31]).
  - Shift amounts of 32 or more are not representable; wrap-around is impossible by port width.
- Registered path:
  - On each rising clk edge with rst_n=0: res_q <= 0 and out_valid <= 0.
  - Otherwise: out_valid <= in_valid. If in_valid=1, res_q <= res; if in_valid=0, res_q holds its value.
- Reset timing:
  - Reset asserted mid-stream clears both registers at the next edge. A transaction presented in that same cycle is dropped.
  - The combinational res is unaffected by reset.
- No X propagation: every stage mux is fully specified.

Test Plan:
- Logical right: A5A5A5A5, amount 1, right=1, arith=0 -> res=52D2D2D2; amount 16 -> 0000A5A5.
- Left: A5A5A5A5, amount 1, right=0 -> 4B4B4B4A; amount 16 -> A5A50000; 00000001 with amount 31 -> 80000000. Setting arith=1 with right=0 gives an identical result.
- Zero shift: A5A5A5A5, amount 0, in every mode -> A5A5A5A5.
- Arithmetic right: A5A5A5A5 with amount 1 -> D2D2D2D2; amount 16 -> FFFFA5A5; 80000001 with amount 31 -> FFFFFFFF; 7FFFFFFF with amount 31 -> 00000000.
- Registered path:
  - Hold rst_n=0 for 2 cycles -> res_q=0 and out_valid=0.
  - Release reset, then apply in_valid=1 with A5A5A5A5, amount 1, logical right -> after the next edge, res_q=52D2D2D2 and out_valid=1.
  - Then apply in_valid=0 -> out_valid=0 and res_q still 52D2D2D2.
  - Then assert rst_n=0 -> res_q=0 at the next edge.
- Randomized sweep: 10k random opranda, amounts and modes -> res matches the reference model (<<, >>, >>>); res_q equals the previous-cycle res whenever out_valid=1.
